// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID, build timestamp) once after reset
// and on every start pulse, then publishes the captured words and a pass/fail/timeout verdict.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1392140734,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_waitrequest,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires on the edge that closes the TIMEOUT_CYCLES-th stalled cycle.
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  state_t      state_q, state_d;
  logic        go_pending_q, go_pending_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      go_pending_q <= 1'b1;
      read_q       <= 1'b0;
      addr_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      id_q         <= '0;
      ts_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      go_pending_q <= go_pending_d;
      read_q       <= read_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      id_q         <= id_d;
      ts_q         <= ts_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    go_pending_d = go_pending_q;
    read_d       = read_q;
    addr_d       = addr_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    id_d         = id_q;
    ts_d         = ts_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (go_pending_q || start) begin
          state_d      = RD_ID;
          read_d       = 1'b1;
          addr_d       = 1'b0;
          go_pending_d = 1'b0;
          cnt_d        = '0;
        end
      end
      RD_ID, RD_TS: begin
        if (!master_waitrequest) begin
          cnt_d = '0;
          if (state_q == RD_ID) begin
            id_d    = master_readdata;
            addr_d  = 1'b1;
            state_d = RD_TS;
          end else begin
            // Timestamp compare uses the live bus word; id_q already holds this run's ID.
            ts_d      = master_readdata;
            read_d    = 1'b0;
            addr_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = (id_q == EXPECTED_ID) && (master_readdata == EXPECTED_TIMESTAMP);
            timeout_d = 1'b0;
            state_d   = DONE;
          end
        end else if (cnt_q == LAST_CNT) begin
          read_d    = 1'b0;
          addr_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          read_d    = 1'b1;
          addr_d    = 1'b0;
          cnt_d     = '0;
          state_d   = RD_ID;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign master_address  = addr_q;
  assign master_read     = read_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Scoreboard bench: stimulus queues the expected verdict per run, a monitor checks each rising done.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] TS_OK = 32'd1392140734;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] master_readdata = '0;
  logic        master_waitrequest = 1'b0;
  logic        master_address, master_read, done, pass, timeout;
  logic [31:0] id_value, timestamp_value;

  niosii_system_sysid_checker #(.TIMEOUT_CYCLES(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .master_address     (master_address),
    .master_read        (master_read),
    .master_readdata    (master_readdata),
    .master_waitrequest (master_waitrequest),
    .done               (done),
    .pass               (pass),
    .timeout            (timeout),
    .id_value           (id_value),
    .timestamp_value    (timestamp_value)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int verdicts = 0;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [31:0] id;
    logic [31:0] ts;
    int          rc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Slave model: fixed words, programmable stall count per read or stuck waitrequest.
  logic [31:0] id_data = 32'd0;
  logic [31:0] ts_data = TS_OK;
  int          wait_n = 0;
  bit          stuck = 1'b0;
  int          phase = 0;
  logic        prev_stall = 1'b0, prev_addr = 1'b0, prev_rd = 1'b0, rst_edge = 1'b1;

  always @(posedge clock) rst_edge = reset;

  always @(negedge clock) begin
    if (prev_stall && !rst_edge && !done) begin
      chk("stall_hold_read", {31'd0, master_read}, {31'd0, prev_rd});
      chk("stall_hold_addr", {31'd0, master_address}, {31'd0, prev_addr});
    end
    master_readdata = master_address ? ts_data : id_data;
    if (master_read && (stuck || phase < wait_n)) begin
      master_waitrequest = 1'b1;
      phase++;
    end else begin
      master_waitrequest = 1'b0;
      phase = 0;
    end
    prev_stall = master_read && master_waitrequest;
    prev_addr  = master_address;
    prev_rd    = master_read;
  end

  // Monitor: length of the read burst plus verdict, checked on each rising done.
  logic done_prev = 1'b0, rd_prev = 1'b0;
  int   run_len = 0;

  always @(negedge clock) begin
    if (master_read) run_len = rd_prev ? run_len + 1 : 1;
    rd_prev = master_read;
    if (done && !done_prev) begin
      verdicts++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_verdict actual=done required=no_run");
      end else begin
        mon_e = exp_q.pop_front();
        chk("pass", {31'd0, pass}, {31'd0, mon_e.pass});
        chk("timeout", {31'd0, timeout}, {31'd0, mon_e.tmo});
        chk("id_value", id_value, mon_e.id);
        chk("timestamp_value", timestamp_value, mon_e.ts);
        chk("read_cycles", run_len, mon_e.rc);
      end
    end
    done_prev = done;
  end

  task automatic push_exp(input logic p, input logic t, input logic [31:0] id,
                          input logic [31:0] ts, input int rc);
    exp_t e;
    e.pass = p; e.tmo = t; e.id = id; e.ts = ts; e.rc = rc;
    exp_q.push_back(e);
  endtask

  task automatic wait_verdicts(input int n, input int budget);
    int k = 0;
    while (verdicts < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (verdicts < n) begin
      total++;
      bad++;
      $display("FAIL wait_verdict actual=%0d required=%0d", verdicts, n);
    end
  endtask

  task automatic wait_rdts(input int budget);
    int k = 0;
    while (!(master_read && master_address) && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (!(master_read && master_address)) begin
      total++;
      bad++;
      $display("FAIL wait_rd_ts actual=idle required=rd_ts");
    end
  endtask

  // Called at a negedge; start is sampled at the following rising edge.
  task automatic pulse_start(input bit in_done);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (in_done) begin
      chk("restart_read", {31'd0, master_read}, 32'd1);
      chk("restart_done_clear", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, {31'd0, master_read}, 32'd0);
    chk({tag, "_addr"}, {31'd0, master_address}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_id"}, id_value, 32'd0);
    chk({tag, "_ts"}, timestamp_value, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_all_zero("reset");

    // Automatic run after reset, zero wait.
    push_exp(1'b1, 1'b0, 32'd0, TS_OK, 2);
    reset = 1'b0;
    wait_verdicts(1, 50);

    // Wrong timestamp.
    ts_data = 32'h12345678;
    push_exp(1'b0, 1'b0, 32'd0, 32'h12345678, 2);
    pulse_start(1'b1);
    wait_verdicts(2, 50);

    // Three stall cycles on each read.
    ts_data = TS_OK;
    wait_n  = 3;
    push_exp(1'b1, 1'b0, 32'd0, TS_OK, 8);
    pulse_start(1'b1);
    wait_verdicts(3, 50);

    // Stuck waitrequest: abort after 4 cycles, id keeps its old value.
    stuck   = 1'b1;
    id_data = 32'hDEADBEEF;
    push_exp(1'b0, 1'b1, 32'd0, TS_OK, 4);
    pulse_start(1'b1);
    wait_verdicts(4, 50);

    // start during RD_TS is ignored; start in DONE reruns.
    stuck   = 1'b0;
    id_data = 32'd0;
    wait_n  = 2;
    push_exp(1'b1, 1'b0, 32'd0, TS_OK, 6);
    pulse_start(1'b1);
    wait_rdts(20);
    pulse_start(1'b0);
    wait_verdicts(5, 50);
    repeat (15) @(negedge clock);
    chk("no_queued_run", verdicts, 5);
    chk("idle_after_ignored_start", {31'd0, master_read}, 32'd0);
    push_exp(1'b1, 1'b0, 32'd0, TS_OK, 6);
    pulse_start(1'b1);
    wait_verdicts(6, 50);

    // Reset while RD_TS is stalled, then the automatic rerun.
    wait_n = 3;
    pulse_start(1'b1);
    wait_rdts(20);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("midreset");
    push_exp(1'b1, 1'b0, 32'd0, TS_OK, 8);
    reset = 1'b0;
    wait_verdicts(7, 50);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
